// File: rtl/imm_ext_pkg.sv
// Shared definitions for the pipelined immediate extender: Ctrl encodings,
// the stage-1 payload carried between decode and the shift/merge stage.
package imm_ext_pkg;

    localparam logic [2:0] IMM_BRANCH = 3'b000;
    localparam logic [2:0] IMM_ITYPE  = 3'b001;
    localparam logic [2:0] IMM_DTYPE  = 3'b010;
    localparam logic [2:0] IMM_CB     = 3'b011;
    localparam logic [2:0] IMM_MOVZ   = 3'b100;
    localparam logic [2:0] IMM_MOVK   = 3'b101;
    localparam logic [2:0] IMM_MOVN   = 3'b110;

    // field is right-aligned; sign/msb let stage 2 widen it to any DATA_W
    typedef struct packed {
        logic [2:0]  ctrl;
        logic [1:0]  hw;
        logic        err;
        logic        sign;
        logic [4:0]  msb;
        logic [25:0] field;
    } s1_payload_t;

    function automatic logic [5:0] hw_shift(input logic [1:0] hw);
        return {hw, 4'b0000};
    endfunction

endpackage

// File: rtl/imm_extender_pipe_if.sv
// Decode-side input and ALU-side output handshake of the immediate extender.
interface imm_extender_pipe_if #(
    parameter int DATA_W = 64
);
    logic [25:0]       Imm26;
    logic [2:0]        Ctrl;
    logic [DATA_W-1:0] BusOld;
    logic              InValid;
    logic              InReady;
    logic [DATA_W-1:0] BusImm;
    logic              ImmValid;
    logic              ImmReady;
    logic              ImmErr;

    modport slave (
        input  Imm26, Ctrl, BusOld, InValid, ImmReady,
        output InReady, BusImm, ImmValid, ImmErr
    );

    modport master (
        output Imm26, Ctrl, BusOld, InValid, ImmReady,
        input  InReady, BusImm, ImmValid, ImmErr
    );
endinterface

// File: rtl/imm_field_extract.sv
// Stage-1 decode: slices the immediate field, picks sign/zero extension and
// flags illegal encodings. Ctrl 110 decodes as MOVN only with IMM_EXT_MOVN_EN.
module imm_field_extract
    import imm_ext_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic [25:0]  imm26,
    input  logic [2:0]   ctrl,
    output s1_payload_t  payload
);

    localparam bit NARROW = (DATA_W == 32);

    logic hw_bad_s;

    // a 32-bit datapath has only two 16-bit lanes
    assign hw_bad_s = NARROW && imm26[22];

    // field slice and extension select per Ctrl encoding
    always_comb begin
        payload      = '0;
        payload.ctrl = ctrl;
        payload.hw   = imm26[22:21];
        case (ctrl)
            IMM_BRANCH: begin
                payload.field = imm26;
                payload.msb   = 5'd25;
                payload.sign  = imm26[25];
            end
            IMM_ITYPE: begin
                payload.field = {14'd0, imm26[21:10]};
                payload.msb   = 5'd11;
                payload.sign  = imm26[21];
            end
            IMM_DTYPE: begin
                payload.field = {17'd0, imm26[20:12]};
                payload.msb   = 5'd8;
                payload.sign  = imm26[20];
            end
            IMM_CB: begin
                payload.field = {7'd0, imm26[23:5]};
                payload.msb   = 5'd18;
                payload.sign  = imm26[23];
            end
            IMM_MOVZ, IMM_MOVK: begin
                payload.field = {10'd0, imm26[20:5]};
                payload.msb   = 5'd15;
                payload.err   = hw_bad_s;
            end
            IMM_MOVN: begin
`ifdef IMM_EXT_MOVN_EN
                payload.field = {10'd0, imm26[20:5]};
                payload.msb   = 5'd15;
                payload.err   = hw_bad_s;
`else
                payload.err   = 1'b1;
`endif
            end
            default: begin
                payload.err   = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/imm_extender_pipe.sv
// Two-stage valid/ready immediate extender (decode in S1, shift/merge in S2).
// Optional MOVN support is enabled with IMM_EXT_MOVN_EN.
module imm_extender_pipe
    import imm_ext_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic                 CLK,
    input  logic                 Reset,
    imm_extender_pipe_if.slave   bus
);

    s1_payload_t       dec_s;
    s1_payload_t       s1_pl_r;
    logic              s1_valid_r;
    logic [DATA_W-1:0] s1_old_r;
    logic              s2_valid_r;
    logic [DATA_W-1:0] s2_data_r;
    logic              s2_err_r;
    logic              s2_adv_s;
    logic              s1_adv_s;
    logic              in_ready_s;
    logic              accept_s;
    logic [DATA_W-1:0] result_s;

    imm_field_extract #(
        .DATA_W (DATA_W)
    ) u_extract (
        .imm26   (bus.Imm26),
        .ctrl    (bus.Ctrl),
        .payload (dec_s)
    );

    // widen the decoded field, then place/merge the 16-bit lane for MOV*
    function automatic logic [DATA_W-1:0] shift_merge(
        input s1_payload_t       p,
        input logic [DATA_W-1:0] old
    );
        logic [DATA_W-1:0] ext;
        logic [DATA_W-1:0] lane;
        logic [DATA_W-1:0] mask;
        logic [DATA_W-1:0] res;
        logic [5:0]        sh;
        sh   = hw_shift(p.hw);
        ext  = {{(DATA_W-26){1'b0}}, p.field}
             | (p.sign ? ({DATA_W{1'b1}} << p.msb) : {DATA_W{1'b0}});
        lane = ext << sh;
        mask = {{(DATA_W-16){1'b0}}, 16'hFFFF} << sh;
        case (p.ctrl)
            IMM_MOVZ: res = lane;
            IMM_MOVK: res = (old & ~mask) | lane;
            IMM_MOVN: res = ~lane;
            default:  res = ext;
        endcase
        return p.err ? {DATA_W{1'b0}} : res;
    endfunction

    assign s2_adv_s   = bus.ImmReady || !s2_valid_r;
    assign s1_adv_s   = s1_valid_r && s2_adv_s;
    assign in_ready_s = !s1_valid_r || s1_adv_s;
    assign accept_s   = bus.InValid && in_ready_s;
    assign result_s   = shift_merge(s1_pl_r, s1_old_r);

    // pipeline registers; S2 only moves when drained or empty, so outputs hold under stall
    always_ff @(posedge CLK) begin
        if (Reset) begin
            s1_valid_r <= 1'b0;
            s1_pl_r    <= '0;
            s1_old_r   <= '0;
            s2_valid_r <= 1'b0;
            s2_data_r  <= '0;
            s2_err_r   <= 1'b0;
        end else begin
            if (accept_s) begin
                s1_valid_r <= 1'b1;
                s1_pl_r    <= dec_s;
                s1_old_r   <= bus.BusOld;
            end else if (s1_adv_s) begin
                s1_valid_r <= 1'b0;
            end
            if (s2_adv_s) begin
                s2_valid_r <= s1_valid_r;
                if (s1_valid_r) begin
                    s2_data_r <= result_s;
                    s2_err_r  <= s1_pl_r.err;
                end
            end
        end
    end

    assign bus.InReady  = in_ready_s;
    assign bus.BusImm   = s2_data_r;
    assign bus.ImmValid = s2_valid_r;
    assign bus.ImmErr   = s2_err_r;

endmodule

// File: tb/tb_imm_extender_pipe.sv
// Self-checking bench for imm_extender_pipe: 64-bit and 32-bit instances,
// directed vectors plus randomized traffic against a behavioural model.
module tb_imm_extender_pipe;

`ifdef IMM_EXT_MOVN_EN
    localparam bit MOVN_EN = 1'b1;
`else
    localparam bit MOVN_EN = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    imm_extender_pipe_if #(.DATA_W(64)) b64();
    imm_extender_pipe_if #(.DATA_W(32)) b32();

    imm_extender_pipe #(.DATA_W(64)) dut64 (.CLK(clk), .Reset(rst), .bus(b64));
    imm_extender_pipe #(.DATA_W(32)) dut32 (.CLK(clk), .Reset(rst), .bus(b32));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [25:0] imm;
        logic [2:0]  ctrl;
        logic [63:0] old;
        logic [63:0] exp;
        logic        err;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] sx(input logic [63:0] v, input int bits);
        logic signed [63:0] t;
        t = $signed(v << (64 - bits));
        return t >>> (64 - bits);
    endfunction

    function automatic logic [25:0] mov_imm(input logic [15:0] imm16, input logic [1:0] hw);
        return {3'b000, hw, imm16, 5'b00000};
    endfunction

    // reference: {err, value} straight from the encoding rules
    function automatic logic [64:0] ref_model(input logic [25:0] imm, input logic [2:0] ctrl,
                                              input logic [63:0] old, input int dw);
        logic [63:0] r;
        logic [63:0] imm16;
        logic [63:0] scale;
        logic        e;
        int          hw;
        hw    = int'(imm[22:21]);
        imm16 = {48'd0, imm[20:5]};
        scale = 64'd1 << (16 * hw);
        e     = 1'b0;
        r     = 64'd0;
        case (ctrl)
            3'd0: r = sx({38'd0, imm}, 26);
            3'd1: r = sx({52'd0, imm[21:10]}, 12);
            3'd2: r = sx({55'd0, imm[20:12]}, 9);
            3'd3: r = sx({45'd0, imm[23:5]}, 19);
            3'd4: begin r = imm16 * scale; e = (dw == 32 && hw >= 2); end
            3'd5: begin
                r = old - ((old / scale) % 64'd65536) * scale + imm16 * scale;
                e = (dw == 32 && hw >= 2);
            end
            3'd6: begin r = ~(imm16 * scale); e = MOVN_EN ? (dw == 32 && hw >= 2) : 1'b1; end
            default: e = 1'b1;
        endcase
        if (e) r = 64'd0;
        if (dw == 32) r = r & 64'h0000_0000_FFFF_FFFF;
        return {e, r};
    endfunction

    task automatic test_reset();
        int seen;
        rst = 1'b1;
        b64.InValid = 1'b1; b64.Imm26 = 26'h3FFFFFF; b64.Ctrl = 3'd0; b64.BusOld = 64'd0; b64.ImmReady = 1'b1;
        b32.InValid = 1'b0; b32.Imm26 = 26'd0; b32.Ctrl = 3'd0; b32.BusOld = 32'd0; b32.ImmReady = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        b64.InValid = 1'b0;
        n_tests++; if (b64.ImmValid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", b64.ImmValid); end
        n_tests++; if (b64.BusImm !== 64'd0) begin n_fail++; $display("FAIL reset_busimm: got %h expected 0", b64.BusImm); end
        n_tests++; if (b64.ImmErr !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", b64.ImmErr); end
        n_tests++; if (b64.InReady !== 1'b1) begin n_fail++; $display("FAIL reset_inready: got %b expected 1", b64.InReady); end
        n_tests++; if (b32.ImmValid !== 1'b0) begin n_fail++; $display("FAIL reset_valid32: got %b expected 0", b32.ImmValid); end
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (b64.ImmValid === 1'b1) seen++;
        end
        n_tests++; if (seen != 0) begin n_fail++; $display("FAIL reset_cycle_input: got %0d outputs expected 0", seen); end
    endtask

    task automatic test_formats();
        vec_t v[7];
        v[0] = '{26'h3FFFFFF, 3'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
        v[1] = '{mov_imm(16'hBEEF, 2'd3), 3'd4, 64'd0, 64'hBEEF_0000_0000_0000, 1'b0};
        v[2] = '{mov_imm(16'hABCD, 2'd1), 3'd5, 64'h1111_2222_3333_4444, 64'h1111_2222_ABCD_4444, 1'b0};
        v[3] = '{26'h1555555, 3'd7, 64'd0, 64'd0, 1'b1};
        v[4] = '{mov_imm(16'h1234, 2'd0), 3'd6, 64'd0, MOVN_EN ? 64'hFFFF_FFFF_FFFF_EDCB : 64'd0, !MOVN_EN};
        v[5] = '{26'h0800000, 3'd3, 64'd0, 64'hFFFF_FFFF_FFFC_0000, 1'b0};
        v[6] = '{mov_imm(16'h0000, 2'd3), 3'd5, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_FFFF_FFFF_FFFF, 1'b0};
        b64.ImmReady = 1'b1;
        for (int i = 0; i < 7; i++) begin
            b64.Imm26 = v[i].imm; b64.Ctrl = v[i].ctrl; b64.BusOld = v[i].old; b64.InValid = 1'b1;
            tick();
            b64.InValid = 1'b0;
            n_tests++; if (b64.ImmValid !== 1'b0) begin n_fail++; $display("FAIL fmt%0d_early_valid: got %b expected 0", i, b64.ImmValid); end
            tick();
            n_tests++;
            if ({b64.ImmValid, b64.ImmErr, b64.BusImm} !== {1'b1, v[i].err, v[i].exp}) begin
                n_fail++;
                $display("FAIL fmt%0d: got valid=%b err=%b imm=%h expected valid=1 err=%b imm=%h",
                         i, b64.ImmValid, b64.ImmErr, b64.BusImm, v[i].err, v[i].exp);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        b64.ImmReady = 1'b1;
        b64.Imm26 = 26'h0200000; b64.Ctrl = 3'd1; b64.BusOld = 64'd0; b64.InValid = 1'b1;
        tick();
        b64.Imm26 = 26'h00FF000; b64.Ctrl = 3'd2;
        n_tests++; if (b64.InReady !== 1'b1) begin n_fail++; $display("FAIL b2b_inready: got %b expected 1", b64.InReady); end
        tick();
        b64.InValid = 1'b0;
        n_tests++;
        if ({b64.ImmValid, b64.BusImm} !== {1'b1, 64'hFFFF_FFFF_FFFF_F800}) begin
            n_fail++; $display("FAIL b2b_itype: got valid=%b imm=%h expected valid=1 imm=fffffffffffff800", b64.ImmValid, b64.BusImm);
        end
        tick();
        n_tests++;
        if ({b64.ImmValid, b64.BusImm} !== {1'b1, 64'h0000_0000_0000_00FF}) begin
            n_fail++; $display("FAIL b2b_dtype: got valid=%b imm=%h expected valid=1 imm=00000000000000ff", b64.ImmValid, b64.BusImm);
        end
        tick();
        n_tests++; if (b64.ImmValid !== 1'b0) begin n_fail++; $display("FAIL b2b_drained: got %b expected 0", b64.ImmValid); end
    endtask

    task automatic test_backpressure();
        vec_t tk[3];
        logic [63:0] held;
        logic        held_seen;
        logic        unstable;
        int          idx;
        int          nout;
        for (int i = 0; i < 3; i++) begin
            tk[i].imm  = 26'($urandom);
            tk[i].ctrl = 3'($urandom_range(0, 5));
            tk[i].old  = {$urandom, $urandom};
            {tk[i].err, tk[i].exp} = ref_model(tk[i].imm, tk[i].ctrl, tk[i].old, 64);
        end
        idx = 0; held = 64'd0; held_seen = 1'b0; unstable = 1'b0;
        b64.ImmReady = 1'b0;
        for (int c = 0; c < 4; c++) begin
            b64.InValid = (idx < 3);
            if (idx < 3) begin b64.Imm26 = tk[idx].imm; b64.Ctrl = tk[idx].ctrl; b64.BusOld = tk[idx].old; end
            @(negedge clk);
            if (b64.InValid && b64.InReady) idx++;
            if (b64.ImmValid === 1'b1) begin
                if (!held_seen) begin held = b64.BusImm; held_seen = 1'b1; end
                else if (b64.BusImm !== held) unstable = 1'b1;
            end
            @(posedge clk); #1;
        end
        n_tests++; if (idx != 2) begin n_fail++; $display("FAIL bp_accepts: got %0d expected 2", idx); end
        n_tests++; if (b64.InReady !== 1'b0) begin n_fail++; $display("FAIL bp_inready: got %b expected 0", b64.InReady); end
        n_tests++; if (!held_seen || held !== tk[0].exp) begin n_fail++; $display("FAIL bp_head: got %h expected %h", held, tk[0].exp); end
        n_tests++; if (unstable) begin n_fail++; $display("FAIL bp_stable: got changing output expected stable"); end
        nout = 0;
        b64.ImmReady = 1'b1;
        for (int c = 0; c < 12 && nout < 3; c++) begin
            b64.InValid = (idx < 3);
            if (idx < 3) begin b64.Imm26 = tk[idx].imm; b64.Ctrl = tk[idx].ctrl; b64.BusOld = tk[idx].old; end
            @(negedge clk);
            if (b64.ImmValid === 1'b1) begin
                n_tests++;
                if ({b64.ImmErr, b64.BusImm} !== {tk[nout].err, tk[nout].exp}) begin
                    n_fail++; $display("FAIL bp_out%0d: got err=%b imm=%h expected err=%b imm=%h",
                                       nout, b64.ImmErr, b64.BusImm, tk[nout].err, tk[nout].exp);
                end
                nout++;
            end
            if (b64.InValid && b64.InReady) idx++;
            @(posedge clk); #1;
        end
        b64.InValid = 1'b0;
        n_tests++; if (nout != 3) begin n_fail++; $display("FAIL bp_count: got %0d outputs expected 3", nout); end
        tick();
    endtask

    task automatic test_random();
        logic [64:0] q[$];
        logic [64:0] e;
        logic [64:0] prev;
        logic        stall_prev;
        stall_prev = 1'b0; prev = '0;
        for (int c = 0; c < 420; c++) begin
            b64.Imm26    = 26'($urandom);
            b64.Ctrl     = 3'($urandom_range(0, 7));
            b64.BusOld   = {$urandom, $urandom};
            b64.InValid  = (c < 400) && ($urandom_range(0, 9) < 7);
            b64.ImmReady = (c >= 400) || ($urandom_range(0, 9) < 6);
            @(negedge clk);
            if (stall_prev) begin
                n_tests++;
                if (b64.ImmValid !== 1'b1 || {b64.ImmErr, b64.BusImm} !== prev) begin
                    n_fail++; $display("FAIL rnd_hold: got valid=%b %h expected valid=1 %h", b64.ImmValid, {b64.ImmErr, b64.BusImm}, prev);
                end
            end
            if (b64.ImmValid === 1'b1 && b64.ImmReady) begin
                n_tests++;
                if (q.size() == 0) begin
                    n_fail++; $display("FAIL rnd_spurious: got %h expected no output", b64.BusImm);
                end else begin
                    e = q.pop_front();
                    if ({b64.ImmErr, b64.BusImm} !== e) begin
                        n_fail++; $display("FAIL rnd_data: got %h expected %h", {b64.ImmErr, b64.BusImm}, e);
                    end
                end
            end
            if (b64.InValid && b64.InReady) q.push_back(ref_model(b64.Imm26, b64.Ctrl, b64.BusOld, 64));
            stall_prev = (b64.ImmValid === 1'b1) && !b64.ImmReady;
            prev = {b64.ImmErr, b64.BusImm};
            @(posedge clk); #1;
        end
        n_tests++; if (q.size() != 0) begin n_fail++; $display("FAIL rnd_leftover: got %0d pending expected 0", q.size()); end
    endtask

    task automatic test_dw32();
        vec_t v[7];
        v[0] = '{mov_imm(16'h1234, 2'd2), 3'd4, 64'd0, 64'd0, 1'b1};
        v[1] = '{mov_imm(16'hBEEF, 2'd1), 3'd4, 64'd0, 64'h0000_0000_BEEF_0000, 1'b0};
        v[2] = '{26'h2000000, 3'd0, 64'd0, 64'h0000_0000_FE00_0000, 1'b0};
        v[3] = '{mov_imm(16'hABCD, 2'd0), 3'd5, 64'h0000_0000_1111_2222, 64'h0000_0000_1111_ABCD, 1'b0};
        v[4] = '{mov_imm(16'hABCD, 2'd3), 3'd5, 64'h0000_0000_1111_2222, 64'd0, 1'b1};
        v[5] = '{mov_imm(16'h00FF, 2'd2), 3'd6, 64'd0, 64'd0, 1'b1};
        v[6] = '{26'h01FFC00, 3'd1, 64'd0, 64'h0000_0000_0000_07FF, 1'b0};
        b32.ImmReady = 1'b1;
        for (int i = 0; i < 7; i++) begin
            b32.Imm26 = v[i].imm; b32.Ctrl = v[i].ctrl; b32.BusOld = v[i].old[31:0]; b32.InValid = 1'b1;
            tick();
            b32.InValid = 1'b0;
            tick();
            n_tests++;
            if ({b32.ImmValid, b32.ImmErr, b32.BusImm} !== {1'b1, v[i].err, v[i].exp[31:0]}) begin
                n_fail++;
                $display("FAIL dw32_%0d: got valid=%b err=%b imm=%h expected valid=1 err=%b imm=%h",
                         i, b32.ImmValid, b32.ImmErr, b32.BusImm, v[i].err, v[i].exp[31:0]);
            end
            tick();
        end
    endtask

    task automatic test_reset_midflight();
        int seen;
        b64.ImmReady = 1'b0;
        b64.Imm26 = 26'h1234567; b64.Ctrl = 3'd0; b64.BusOld = 64'd0; b64.InValid = 1'b1;
        tick();
        b64.Imm26 = mov_imm(16'hCAFE, 2'd2); b64.Ctrl = 3'd4;
        tick();
        n_tests++;
        if ({b64.ImmValid, b64.InReady} !== 2'b10) begin
            n_fail++; $display("FAIL mid_full: got valid=%b inready=%b expected valid=1 inready=0", b64.ImmValid, b64.InReady);
        end
        b64.Imm26 = 26'h0ABCDEF; b64.Ctrl = 3'd3;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        b64.InValid = 1'b0;
        b64.ImmReady = 1'b1;
        n_tests++;
        if ({b64.ImmValid, b64.ImmErr, b64.BusImm} !== {2'b00, 64'd0}) begin
            n_fail++; $display("FAIL mid_reset: got valid=%b err=%b imm=%h expected valid=0 err=0 imm=0",
                               b64.ImmValid, b64.ImmErr, b64.BusImm);
        end
        n_tests++; if (b64.InReady !== 1'b1) begin n_fail++; $display("FAIL mid_inready: got %b expected 1", b64.InReady); end
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (b64.ImmValid === 1'b1) seen++;
        end
        n_tests++; if (seen != 0) begin n_fail++; $display("FAIL mid_discard: got %0d outputs expected 0", seen); end
    endtask

    initial begin
        test_reset();
        test_formats();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_dw32();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
